fetch_unit: RTL



---
 rtl/sisc_pkg.sv | 23 ++
 rtl/fetch_queue.sv | 71 +++++++
 rtl/fetch_unit.sv | 85 ++++++++
 3 files changed

// File: rtl/sisc_pkg.sv
// Shared types and constants for the SISC front end.
// Holds the fetch-to-decode bundle and opcode helpers.
package sisc_pkg;

  localparam int INSTR_W    = 32;
  localparam int ADDR_W     = 16;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;

  localparam logic [3:0] HLT_OP = 4'hF;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } if_id_t;

  function automatic logic [3:0] opcode(
    input logic [INSTR_W-1:0] w
  );
    return w[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular instruction queue between fetch and decode.
// Supports flushing everything or everything but the head.
module fetch_queue
  import sisc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_f,
  input  logic                   push,
  input  if_id_t                 push_data,
  input  logic                   pop,
  input  logic                   flush_keep_head,
  input  logic                   flush_all,
  output if_id_t                 head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   C_ONE  = 1;
  localparam logic [PW:0]   C_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] P_ONE  = 1;

  if_id_t mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_nxt;

  assign rd_nxt = rd_ptr + P_ONE;
  assign head   = mem[rd_ptr];
  assign empty  = count == '0;
  assign full   = count == C_FULL;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_all) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_keep_head) begin
      // only the head survives, unless it leaves now
      if (pop) begin
        rd_ptr <= rd_nxt;
        wr_ptr <= rd_nxt;
        count  <= '0;
      end else if (!empty) begin
        wr_ptr <= rd_nxt;
        count  <= C_ONE;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + P_ONE;
      if (pop)  rd_ptr <= rd_nxt;
      unique case ({push, pop})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, feeds the instruction queue,
// handles branch redirects and stops at HLT.
module fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HLT_OP   = 4'hF
) (
  input  logic        clk,
  input  logic        rst_f,
  output logic [15:0] im_addr,
  input  logic [31:0] im_data,
  output logic [31:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        halted
);

  sisc_pkg::if_id_t head;
  sisc_pkg::if_id_t wr_ent;

  logic [$clog2(DEPTH):0] q_count;
  logic q_full;
  logic q_empty;

  logic [15:0] pc;
  logic halt_pend;
  logic deq;
  logic enq;
  logic redirect;
  logic head_hlt;

  assign im_addr  = pc;
  assign wr_ent   = {pc, im_data};
  assign ir_valid = q_count != '0;
  assign ir       = q_empty ? '0 : head.instr;
  assign ir_pc    = q_empty ? '0 : head.pc;

  assign deq      = ir_valid & ir_ready;
  assign head_hlt = sisc_pkg::opcode(head.instr) == HLT_OP;
  assign redirect = br_taken & ~halted;
  assign enq      = ~halted & ~halt_pend & ~br_taken
                  & (~q_full | deq);

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk             (clk),
    .rst_f           (rst_f),
    .push            (enq),
    .push_data       (wr_ent),
    .pop             (deq),
    .flush_keep_head (redirect),
    .flush_all       (deq & head_hlt),
    .head            (head),
    .full            (q_full),
    .empty           (q_empty),
    .count           (q_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      pc        <= RESET_PC;
      halt_pend <= 1'b0;
      halted    <= 1'b0;
    end else begin
      unique case (1'b1)
        redirect: begin
          pc        <= br_target;
          halt_pend <= 1'b0;
        end
        enq: begin
          pc <= pc + 16'd1;
          if (sisc_pkg::opcode(im_data) == HLT_OP)
            halt_pend <= 1'b1;
        end
        default: ;
      endcase
      if (deq & head_hlt) halted <= 1'b1;
    end
  end

endmodule
